// File: rtl/l2_port_arbiter_if.sv
// l2_port_arbiter_if: bus bundle between two OBI-style masters, the arbiter
// and the L2 SRAM port.
//   m0_* / m1_* : master request (req/we/be/addr/wdata) and grant/response
//                 (gnt/rvalid/rdata/err)
//   mem_*       : SRAM request (req/we/be/addr/wdata), accept (gnt) and
//                 read data (rdata, one cycle after an accepted request)
// Modports: slave = arbiter side, master = environment (masters + SRAM model).
interface l2_port_arbiter_if #(
    parameter int MEM_AW = 14
);
    logic              m0_req_i;
    logic              m0_we_i;
    logic [3:0]        m0_be_i;
    logic [31:0]       m0_addr_i;
    logic [31:0]       m0_wdata_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [31:0]       m0_rdata_o;
    logic              m0_err_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [3:0]        m1_be_i;
    logic [31:0]       m1_addr_i;
    logic [31:0]       m1_wdata_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [31:0]       m1_rdata_o;
    logic              m1_err_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic              mem_gnt_i;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rdata_i
    );
endinterface

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: two-master round-robin arbiter in front of a single-port
// L2 SRAM. Out-of-window accesses are granted locally and answered with err.
//   clk_i, rst_n   : clock, asynchronous active-low reset
//   bus (slave)    : m0/m1 request+response, SRAM request+read data
//   conflict_cnt_o : saturating count of cycles where both masters requested
module l2_port_arbiter #(
    parameter logic [31:0] L2_BASE  = 32'h0000_0000,
    parameter int          L2_WORDS = 16384,
    parameter int          MEM_AW   = $clog2(L2_WORDS)
) (
    input  logic                    clk_i,
    input  logic                    rst_n,
    l2_port_arbiter_if.slave        bus,
    output logic [15:0]             conflict_cnt_o
);
    localparam logic [32:0] WIN_BYTES = 33'(L2_WORDS) << 2;

    typedef struct packed {
        logic valid;
        logic owner;
        logic err;
        logic rd;      // in-range read: return SRAM data
    } rsp_t;

    logic [1:0]             req, we;
    logic [1:0][3:0]        be;
    logic [1:0][31:0]       addr, wdata;
    logic [1:0][32:0]       off;
    logic [1:0]             in_rng;
    logic [1:0]             gnt, rvalid, err;
    logic [1:0][31:0]       rdata;

    logic                   last_grant;
    logic                   both, any, sel, win_in, fire;
    rsp_t                   rsp_q;
    logic [15:0]            cnt_q;

    assign req   = {bus.m1_req_i,   bus.m0_req_i};
    assign we    = {bus.m1_we_i,    bus.m0_we_i};
    assign be    = {bus.m1_be_i,    bus.m0_be_i};
    assign addr  = {bus.m1_addr_i,  bus.m0_addr_i};
    assign wdata = {bus.m1_wdata_i, bus.m0_wdata_i};

    // 33-bit subtraction: bit 32 set means addr is below the window base.
    for (genvar i = 0; i < 2; i++) begin : g_dec
        assign off[i]    = {1'b0, addr[i]} - {1'b0, L2_BASE};
        assign in_rng[i] = ~off[i][32] && (off[i] < WIN_BYTES);
    end

    // last_grant=1 means m1 was served last, so m0 wins the next conflict.
    assign both   = req[0] & req[1];
    assign sel    = both ? ~last_grant : req[1];
    assign any    = (|req) & rst_n;
    assign win_in = in_rng[sel];
    assign fire   = any & (win_in ? bus.mem_gnt_i : 1'b1);
    assign gnt    = {fire & sel, fire & ~sel};

    always_comb begin
        bus.mem_req_o   = any & win_in;
        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (bus.mem_req_o) begin
            bus.mem_we_o    = we[sel];
            bus.mem_be_o    = be[sel];
            bus.mem_addr_o  = off[sel][MEM_AW+1:2];
            bus.mem_wdata_o = wdata[sel];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q      <= '0;
            last_grant <= 1'b1;
            cnt_q      <= '0;
        end else begin
            rsp_q.valid <= fire;
            if (fire) begin
                rsp_q.owner <= sel;
                rsp_q.err   <= ~win_in;
                rsp_q.rd    <= win_in & ~we[sel];
                last_grant  <= sel;
            end
            if (both && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_rsp
        assign rvalid[i] = rsp_q.valid & (rsp_q.owner == 1'(i));
        assign err[i]    = rvalid[i] & rsp_q.err;
        assign rdata[i]  = (rvalid[i] & rsp_q.rd) ? bus.mem_rdata_i : 32'h0;
    end

    assign bus.m0_gnt_o    = gnt[0];
    assign bus.m0_rvalid_o = rvalid[0];
    assign bus.m0_err_o    = err[0];
    assign bus.m0_rdata_o  = rdata[0];
    assign bus.m1_gnt_o    = gnt[1];
    assign bus.m1_rvalid_o = rvalid[1];
    assign bus.m1_err_o    = err[1];
    assign bus.m1_rdata_o  = rdata[1];

    assign conflict_cnt_o  = cnt_q;
endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed table of per-cycle vectors plus sequences for
// round-robin after reset, reset with a pending response, and counter
// saturation.
module tb_l2_port_arbiter;
    logic        clk;
    logic        rst_n;
    logic [15:0] cnt;

    l2_port_arbiter_if #(.MEM_AW(14)) bus ();

    l2_port_arbiter #(
        .L2_BASE (32'h0000_0000),
        .L2_WORDS(16384)
    ) dut (
        .clk_i         (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .conflict_cnt_o(cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        r0, we0;
        logic [3:0]  be0;
        logic [31:0] a0, wd0;
        logic        r1, we1;
        logic [3:0]  be1;
        logic [31:0] a1, wd1;
        logic        mg;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        g0, g1, mreq, mwe;
        logic [3:0]  mbe;
        logic [13:0] maddr;
        logic [31:0] mwd;
        logic        rv0, err0;
        logic [31:0] rd0;
        logic        rv1, err1;
        logic [31:0] rd1;
        logic [15:0] cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 18;
    vec_t vt [NV];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic in_t mi(logic r0, logic we0, logic [3:0] be0, logic [31:0] a0,
                               logic [31:0] wd0, logic r1, logic we1, logic [3:0] be1,
                               logic [31:0] a1, logic [31:0] wd1, logic mg, logic [31:0] mrd);
        return '{r0, we0, be0, a0, wd0, r1, we1, be1, a1, wd1, mg, mrd};
    endfunction

    function automatic out_t mo(logic g0, logic g1, logic mreq, logic mwe, logic [3:0] mbe,
                                logic [13:0] maddr, logic [31:0] mwd, logic rv0, logic err0,
                                logic [31:0] rd0, logic rv1, logic err1, logic [31:0] rd1,
                                logic [15:0] c);
        return '{g0, g1, mreq, mwe, mbe, maddr, mwd, rv0, err0, rd0, rv1, err1, rd1, c};
    endfunction

    function automatic out_t sample();
        out_t o;
        o.g0 = bus.m0_gnt_o;       o.g1 = bus.m1_gnt_o;
        o.mreq = bus.mem_req_o;    o.mwe = bus.mem_we_o;
        o.mbe = bus.mem_be_o;      o.maddr = bus.mem_addr_o;
        o.mwd = bus.mem_wdata_o;
        o.rv0 = bus.m0_rvalid_o;   o.err0 = bus.m0_err_o;  o.rd0 = bus.m0_rdata_o;
        o.rv1 = bus.m1_rvalid_o;   o.err1 = bus.m1_err_o;  o.rd1 = bus.m1_rdata_o;
        o.cnt = cnt;
        return o;
    endfunction

    task automatic drive(input in_t v);
        bus.m0_req_i = v.r0;  bus.m0_we_i = v.we0; bus.m0_be_i = v.be0;
        bus.m0_addr_i = v.a0; bus.m0_wdata_i = v.wd0;
        bus.m1_req_i = v.r1;  bus.m1_we_i = v.we1; bus.m1_be_i = v.be1;
        bus.m1_addr_i = v.a1; bus.m1_wdata_i = v.wd1;
        bus.mem_gnt_i = v.mg; bus.mem_rdata_i = v.mrd;
    endtask

    task automatic chk_o(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Ends at posedge+1 with reset released and inputs idle.
    task automatic do_reset();
        drive(mi(0,0,0,0,0, 0,0,0,0,0, 0,0));
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    in_t  idle;
    in_t  both_rd;
    out_t ex;
    logic prev_g1;
    int   bad;

    initial begin
        idle    = mi(0,0,0,0,0, 0,0,0,0,0, 0,0);
        both_rd = mi(1,0,4'hF,32'h10,0, 1,0,4'hF,32'h20,0, 1,0);

        //            m0: req we be addr wdata    m1: req we be addr wdata      mg  mrd
        vt[0]  = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,0),
                   mo(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0)};
        vt[1]  = '{mi(0,0,0,0,0, 1,1,4'hF,32'h0,32'hABBA_ABBA, 1,0),
                   mo(0,1,1,1,4'hF,14'h0,32'hABBA_ABBA, 0,0,0, 0,0,0, 0)};
        vt[2]  = '{mi(0,0,0,0,0, 1,0,4'hF,32'h0,0, 1,0),
                   mo(0,1,1,0,4'hF,14'h0,0, 0,0,0, 1,0,0, 0)};
        vt[3]  = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,32'hABBA_ABBA),
                   mo(0,0,0,0,0,0,0, 0,0,0, 1,0,32'hABBA_ABBA, 0)};
        vt[4]  = '{mi(0,0,0,0,0, 1,0,4'hF,32'h0001_0000,0, 0,0),
                   mo(0,1,0,0,0,0,0, 0,0,0, 0,0,0, 0)};
        vt[5]  = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,32'hDEAD_BEEF),
                   mo(0,0,0,0,0,0,0, 0,0,0, 1,1,0, 0)};
        vt[6]  = '{mi(1,0,4'hF,32'h100,0, 0,0,0,0,0, 0,0),
                   mo(0,0,1,0,4'hF,14'h40,0, 0,0,0, 0,0,0, 0)};
        vt[7]  = vt[6];
        vt[8]  = vt[6];
        vt[9]  = '{mi(1,0,4'hF,32'h100,0, 0,0,0,0,0, 1,0),
                   mo(1,0,1,0,4'hF,14'h40,0, 0,0,0, 0,0,0, 0)};
        vt[10] = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,32'h1234_5678),
                   mo(0,0,0,0,0,0,0, 1,0,32'h1234_5678, 0,0,0, 0)};
        vt[11] = '{mi(1,0,4'hF,32'h10,0, 1,0,4'hF,32'h20,0, 1,0),
                   mo(0,1,1,0,4'hF,14'h8,0, 0,0,0, 0,0,0, 0)};
        vt[12] = '{mi(1,0,4'hF,32'h10,0, 1,0,4'hF,32'h20,0, 1,32'h1111_1111),
                   mo(1,0,1,0,4'hF,14'h4,0, 0,0,0, 1,0,32'h1111_1111, 1)};
        vt[13] = '{mi(1,1,4'hF,32'h0002_0000,32'h55, 0,0,0,0,0, 0,32'h2222_2222),
                   mo(1,0,0,0,0,0,0, 1,0,32'h2222_2222, 0,0,0, 2)};
        vt[14] = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,32'h3333_3333),
                   mo(0,0,0,0,0,0,0, 1,1,0, 0,0,0, 2)};
        vt[15] = '{mi(1,1,4'h3,32'h0000_FFFC,32'hCAFE_F00D, 0,0,0,0,0, 1,0),
                   mo(1,0,1,1,4'h3,14'h3FFF,32'hCAFE_F00D, 0,0,0, 0,0,0, 2)};
        vt[16] = '{mi(0,0,0,0,0, 1,0,4'hF,32'hFFFF_FFFC,0, 1,32'h4444_4444),
                   mo(0,1,0,0,0,0,0, 1,0,0, 0,0,0, 2)};
        vt[17] = '{mi(0,0,0,0,0, 0,0,0,0,0, 0,32'h5555_5555),
                   mo(0,0,0,0,0,0,0, 0,0,0, 1,1,0, 2)};

        // Reset state: requests present while reset is held must not leak out.
        rst_n = 1'b0;
        drive(both_rd);
        @(posedge clk); #1;
        @(negedge clk);
        chk_o("reset_outputs", sample(), mo(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0));
        @(posedge clk);
        do_reset();

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].i);
            @(negedge clk);
            chk_o($sformatf("vec%0d", i), sample(), vt[i].o);
            @(posedge clk); #1;
        end

        // Round-robin from reset: m0, m1, m0, m1 with responses one cycle later.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_t v;
            v = (k < 4) ? both_rd : idle;
            v.mrd = 32'hA000_0000 + 32'(k);
            drive(v);
            ex = mo(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 16'(k));
            if (k < 4) begin
                ex.g0 = (k % 2 == 0);
                ex.g1 = (k % 2 == 1);
                ex.mreq = 1'b1;
                ex.mbe = 4'hF;
                ex.maddr = ex.g0 ? 14'h4 : 14'h8;
            end
            if (k > 0) begin
                ex.rv0 = ((k - 1) % 2 == 0);
                ex.rv1 = ((k - 1) % 2 == 1);
                ex.rd0 = ex.rv0 ? v.mrd : 32'h0;
                ex.rd1 = ex.rv1 ? v.mrd : 32'h0;
            end
            @(negedge clk);
            chk_o($sformatf("rr%0d", k), sample(), ex);
            @(posedge clk); #1;
        end

        // Reset right after a granted read discards the pending response.
        drive(mi(1,0,4'hF,32'h40,0, 0,0,0,0,0, 1,32'h7777_7777));
        @(negedge clk);
        chk_v("pre_rst_gnt", {31'h0, bus.m0_gnt_o}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(both_rd);
        @(negedge clk);
        chk_o("rst_pending", sample(), mo(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0));
        @(posedge clk); #1;
        drive(idle);
        rst_n = 1'b1;
        @(negedge clk);
        chk_o("post_rst_idle", sample(), mo(0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0));
        @(posedge clk); #1;
        drive(both_rd);
        @(negedge clk);
        chk_v("post_rst_first", {30'h0, bus.m1_gnt_o, bus.m0_gnt_o}, 32'h1);
        @(posedge clk); #1;

        // Long conflict run: counter saturates, grants keep alternating.
        do_reset();
        drive(both_rd);
        prev_g1 = 1'b1;
        bad = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            if (!$onehot({bus.m1_gnt_o, bus.m0_gnt_o}) || bus.m1_gnt_o == prev_g1)
                bad++;
            prev_g1 = bus.m1_gnt_o;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk_v("sat_cnt", {16'h0, cnt}, 32'h0000_FFFF);
        chk_v("sat_alternate", 32'(bad), 32'h0);
        chk_v("sat_still_alt", {31'h0, bus.m1_gnt_o}, {31'h0, ~prev_g1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
